// File: rtl/i2s_stream_pkg.sv
// Shared definitions for the i2s frame streamer and the i2s_mask node array:
// frame geometry, header field positions and the streamer state type.
package i2s_stream_pkg;

    localparam int HEADER_BITS = 16;
    localparam int WORD_BITS   = 16;
    localparam int MOD_W       = 4;
    localparam int ROW_W       = 6;

    localparam int HDR_NX_LSB  = 12;
    localparam int HDR_NY_LSB  = 8;
    localparam int HDR_ROW_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DONE
    } stream_state_t;

    // Bits [7:6] of the header are reserved and always zero.
    function automatic logic [HEADER_BITS-1:0] pack_header(
        input logic [MOD_W-1:0] nx,
        input logic [MOD_W-1:0] ny,
        input logic [ROW_W-1:0] row
    );
        logic [HEADER_BITS-1:0] hdr;
        hdr = '0;
        hdr[HDR_NX_LSB +: MOD_W]  = nx;
        hdr[HDR_NY_LSB +: MOD_W]  = ny;
        hdr[HDR_ROW_LSB +: ROW_W] = row;
        return hdr;
    endfunction

endpackage

// File: rtl/i2s_frame_streamer_if.sv
// Control, row-buffer read port and serial bus of the frame streamer.
// The streamer side is the master; the row buffer / controller side is the slave.
interface i2s_frame_streamer_if;
    import i2s_stream_pkg::*;

    logic                 start;
    logic [MOD_W-1:0]     num_modules_x;
    logic [MOD_W-1:0]     num_modules_y;
    logic                 busy;
    logic                 frame_done;
    logic [ROW_W-1:0]     row_num;
    logic                 rd_en;
    logic [7:0]           rd_addr;
    logic [WORD_BITS-1:0] rd_data;
    logic                 i2s_clk;
    logic                 i2s_data;

    modport master (
        input  start, num_modules_x, num_modules_y, rd_data,
        output busy, frame_done, row_num, rd_en, rd_addr, i2s_clk, i2s_data
    );

    modport slave (
        output start, num_modules_x, num_modules_y, rd_data,
        input  busy, frame_done, row_num, rd_en, rd_addr, i2s_clk, i2s_data
    );

endinterface

// File: rtl/i2s_bit_clk_gen.sv
// Bit clock generator: CLK_DIV system cycles per half-period while enabled.
// Strobes flag the cycle whose closing edge makes i2s_clk rise or fall.
module i2s_bit_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic i2s_clk,
    output logic rise_stb,
    output logic fall_stb
);

    logic [7:0] div_cnt;
    logic       half_tc;

    assign half_tc  = enable && (div_cnt == 8'(CLK_DIV - 1));
    assign rise_stb = half_tc && !i2s_clk;
    assign fall_stb = half_tc && i2s_clk;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            div_cnt <= 8'd0;
            i2s_clk <= 1'b0;
        end else if (half_tc) begin
            div_cnt <= 8'd0;
            i2s_clk <= ~i2s_clk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_frame_streamer.sv
// Row frame source for the i2s_mask array: serialises a header plus one
// word per module, fetched from the row buffer one word ahead of use.
module i2s_frame_streamer
    import i2s_stream_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int ROW_WRAP = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    i2s_frame_streamer_if.master bus
);

    // state      | meaning
    // ST_IDLE    | waiting for start; accept prefetches word 0
    // ST_HEADER  | shifting out the 16-bit header
    // ST_PAYLOAD | shifting out the module words
    // ST_DONE    | one-cycle frame_done pulse, row_num advances

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_WRAP - 1);

    stream_state_t        state, state_nxt;
    logic [MOD_W-1:0]     nx_q, ny_q;
    logic [ROW_W-1:0]     row_q;
    logic [12:0]          bit_cnt;
    logic [WORD_BITS-1:0] shift_q, hold_q;
    logic [8:0]           rd_ptr;
    logic                 rd_en_q, rd_req;
    logic [8:0]           n_words;
    logic [12:0]          frame_bits;
    logic                 clk_en, rise_stb, fall_stb;
    logic                 accept, frame_end, word_end, fetch;

    // bit_cnt counts rising edges already delivered, so at a falling edge
    // a multiple of 16 means a word (or the header) has just been completed.
    assign n_words    = ({5'd0, nx_q} + 9'd1) * ({5'd0, ny_q} + 9'd1);
    assign frame_bits = {n_words, 4'd0} + 13'(HEADER_BITS);
    assign accept     = (state == ST_IDLE) && bus.start;
    assign frame_end  = fall_stb && (bit_cnt == frame_bits);
    assign word_end   = fall_stb && (bit_cnt[3:0] == 4'd0) && !frame_end;
    assign fetch      = word_end && (rd_ptr < n_words);

    i2s_bit_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (clk_en),
        .i2s_clk  (bus.i2s_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        clk_en         = 1'b0;
        bus.busy       = 1'b0;
        bus.frame_done = 1'b0;
        rd_req         = 1'b0;
        bus.rd_addr    = rd_ptr[7:0];
        case (state)
            ST_IDLE: begin
                bus.rd_addr = 8'd0;
                if (bus.start) begin
                    rd_req    = 1'b1;
                    state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                clk_en   = 1'b1;
                bus.busy = 1'b1;
                rd_req   = fetch;
                if (word_end) state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                clk_en   = 1'b1;
                bus.busy = 1'b1;
                rd_req   = fetch;
                if (frame_end) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.frame_done = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.rd_en    = rd_req && rst_n;
    assign bus.row_num  = row_q;
    assign bus.i2s_data = shift_q[WORD_BITS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nx_q    <= '0;
            ny_q    <= '0;
            row_q   <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            rd_ptr  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= bus.rd_en;
            if (rd_en_q) hold_q <= bus.rd_data;
            if (accept) begin
                nx_q    <= bus.num_modules_x;
                ny_q    <= bus.num_modules_y;
                shift_q <= pack_header(bus.num_modules_x, bus.num_modules_y, row_q);
                bit_cnt <= '0;
                rd_ptr  <= 9'd1;
            end
            if (rise_stb) bit_cnt <= bit_cnt + 13'd1;
            if (frame_end) begin
                shift_q <= '0;
            end else if (word_end) begin
                shift_q <= hold_q;
                if (fetch) rd_ptr <= rd_ptr + 9'd1;
            end else if (fall_stb) begin
                shift_q <= {shift_q[WORD_BITS-2:0], 1'b0};
            end
            if (state == ST_DONE) row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end
    end

endmodule

// File: tb/tb_i2s_frame_streamer.sv
// Bench for i2s_frame_streamer: a frame-level model (bit list + timing
// arithmetic) checked every cycle, plus literal expectations per scenario.
module tb_i2s_frame_streamer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_frame_streamer_if bus_a ();
    i2s_frame_streamer_if bus_b ();

    i2s_frame_streamer #(.CLK_DIV(2), .ROW_WRAP(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
    i2s_frame_streamer #(.CLK_DIV(1), .ROW_WRAP(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));

    // Row buffer: word k holds 16'hA000 + k, one cycle read latency.
    always @(posedge clk) begin
        if (bus_a.rd_en) bus_a.rd_data <= 16'hA000 + 16'(bus_a.rd_addr);
        if (bus_b.rd_en) bus_b.rd_data <= 16'hA000 + 16'(bus_b.rd_addr);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          sel = 1'b0;
    bit          active = 1'b0;
    int          acc_cyc = 0, cd = 2, nbits = 0, exp_row = 0;
    int          rd_seen = 0, n_exp = 0, rises = 0, busy_cycles = 0, done_t = -1;
    bit          exp_bits[$];
    logic [15:0] rx_sh = '0, rx_hdr = '0;
    logic        rx_prev = 1'b0;
    int          row_lit[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    logic       s_busy, s_done, s_clk, s_data, s_rd_en;
    logic [5:0] s_row;
    logic [7:0] s_rd_addr;
    assign s_busy    = sel ? bus_b.busy       : bus_a.busy;
    assign s_done    = sel ? bus_b.frame_done : bus_a.frame_done;
    assign s_clk     = sel ? bus_b.i2s_clk    : bus_a.i2s_clk;
    assign s_data    = sel ? bus_b.i2s_data   : bus_a.i2s_data;
    assign s_rd_en   = sel ? bus_b.rd_en      : bus_a.rd_en;
    assign s_row     = sel ? bus_b.row_num    : bus_a.row_num;
    assign s_rd_addr = sel ? bus_b.rd_addr    : bus_a.rd_addr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic load_model(input logic [3:0] nx, input logic [3:0] ny);
        logic [15:0] hdr, w;
        int n;
        n   = (int'(nx) + 1) * (int'(ny) + 1);
        hdr = {nx, ny, 2'b00, 6'(exp_row)};
        exp_bits.delete();
        for (int i = 15; i >= 0; i--) exp_bits.push_back(hdr[i]);
        for (int k = 0; k < n; k++) begin
            w = 16'hA000 + 16'(k);
            for (int i = 15; i >= 0; i--) exp_bits.push_back(w[i]);
        end
        nbits = exp_bits.size();
        n_exp = n;
        rd_seen = 0; rises = 0; busy_cycles = 0; done_t = -1;
        rx_prev = 1'b0; rx_sh = '0; rx_hdr = '0;
        acc_cyc = cyc;
        active  = 1'b1;
    endtask

    // Called at posedge+1; holds start for exactly one cycle.
    task automatic drive_start(input bit accept_it, input logic [3:0] nx, input logic [3:0] ny);
        if (sel) begin
            bus_b.start = 1'b1; bus_b.num_modules_x = nx; bus_b.num_modules_y = ny;
        end else begin
            bus_a.start = 1'b1; bus_a.num_modules_x = nx; bus_a.num_modules_y = ny;
        end
        if (accept_it) load_model(nx, ny);
        @(posedge clk);
        #1;
        bus_a.start = 1'b0; bus_a.num_modules_x = 4'h5; bus_a.num_modules_y = 4'h5;
        bus_b.start = 1'b0; bus_b.num_modules_x = 4'h5; bus_b.num_modules_y = 4'h5;
    endtask

    // Returns right at the posedge that ends the DONE cycle.
    task automatic wait_done(input int budget);
        int n = 0;
        while (active && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (active) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: frame_done not seen within %0d cycles", budget);
            active = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; active = 1'b0; exp_row = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state_a", {bus_a.busy, bus_a.frame_done, bus_a.i2s_clk, bus_a.i2s_data,
                              bus_a.rd_en, bus_a.row_num, bus_a.rd_addr}, 32'd0);
        chk("reset_state_b", {bus_b.busy, bus_b.frame_done, bus_b.i2s_clk, bus_b.i2s_data,
                              bus_b.rd_en, bus_b.row_num, bus_b.rd_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Every-cycle comparison against the frame model.
    always @(negedge clk) begin : cmp
        int t;
        logic [3:0] got, exp;
        if (rst_n) begin
            t   = cyc - acc_cyc;
            exp = 4'b0000;
            if (active && t >= 1 && t <= 2 * cd * nbits)
                exp = {1'b1, 1'b0, 1'(((t - 1) / cd) % 2), exp_bits[(t - 1) / (2 * cd)]};
            else if (active && t == 2 * cd * nbits + 1)
                exp = 4'b0100;
            got = {s_busy, s_done, s_clk, s_data};
            chk("busy_done_clk_data", 32'(got), 32'(exp));
            if (!(active && t == 2 * cd * nbits + 1))
                chk("row_num", 32'(s_row), 32'(exp_row));
            if (s_rd_en) begin
                chk("rd_en_in_frame", 32'(active && rd_seen < n_exp), 32'd1);
                chk("rd_addr", 32'(s_rd_addr), 32'(rd_seen));
                rd_seen++;
            end
            if (s_clk && !rx_prev) begin
                rises++;
                rx_sh = {rx_sh[14:0], s_data};
                if (rises == 16) rx_hdr = rx_sh;
            end
            rx_prev = s_clk;
            if (s_busy) busy_cycles++;
            if (active && t == 2 * cd * nbits + 1) begin
                chk("rd_count", 32'(rd_seen), 32'(n_exp));
                done_t  = t;
                active  = 1'b0;
                exp_row = (exp_row + 1) % 8;
            end
        end
    end

    initial begin
        bus_a.start = 1'b0; bus_a.num_modules_x = '0; bus_a.num_modules_y = '0;
        bus_b.start = 1'b0; bus_b.num_modules_x = '0; bus_b.num_modules_y = '0;
        do_reset();

        // 4x4 frame straight after reset
        @(posedge clk); #1;
        drive_start(1'b1, 4'd3, 4'd3);
        wait_done(2000);
        chk("hdr_4x4", 32'(rx_hdr), 32'h3300);
        chk("rises_4x4", 32'(rises), 32'd272);
        chk("done_cycle_4x4", 32'(done_t), 32'd1089);
        chk("rd_pulses_4x4", 32'(rd_seen), 32'd16);

        // start pulsed mid-payload is ignored
        @(posedge clk); #1;
        drive_start(1'b1, 4'd3, 4'd3);
        repeat (300) @(posedge clk);
        #1;
        drive_start(1'b0, 4'd0, 4'd0);
        wait_done(2000);
        chk("hdr_row1", 32'(rx_hdr), 32'h3301);
        chk("rises_busy_start", 32'(rises), 32'd272);
        repeat (20) @(posedge clk);

        // reset for one cycle during word 5
        #1;
        drive_start(1'b1, 4'd3, 4'd3);
        repeat (400) @(posedge clk);
        #1;
        rst_n = 1'b0; active = 1'b0; exp_row = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {s_busy, s_done, s_clk, s_data, s_row}, 32'd0);
        @(posedge clk); #1;
        drive_start(1'b1, 4'd3, 4'd3);
        wait_done(2000);
        chk("hdr_after_abort", 32'(rx_hdr), 32'h3300);

        // 1x1 frame
        do_reset();
        @(posedge clk); #1;
        drive_start(1'b1, 4'd0, 4'd0);
        wait_done(500);
        chk("hdr_1x1", 32'(rx_hdr), 32'h0000);
        chk("rises_1x1", 32'(rises), 32'd32);
        chk("busy_cycles_1x1", 32'(busy_cycles), 32'd128);
        chk("rd_pulses_1x1", 32'(rd_seen), 32'd1);

        // nine back-to-back frames across the row wrap
        do_reset();
        @(posedge clk); #1;
        for (int f = 0; f < 9; f++) begin
            drive_start(1'b1, 4'd3, 4'd3);
            wait_done(2000);
            chk("row_wrap_hdr", 32'(rx_hdr[5:0]), 32'(row_lit[f]));
            chk("row_wrap_done_cycle", 32'(done_t), 32'd1089);
            #1;
        end
        @(negedge clk);
        chk("row_after_wrap", 32'(s_row), 32'd1);

        // largest frame at CLK_DIV=1
        do_reset();
        sel = 1'b1;
        cd  = 1;
        @(posedge clk); #1;
        drive_start(1'b1, 4'd15, 4'd15);
        wait_done(9000);
        chk("hdr_max", 32'(rx_hdr), 32'hFF00);
        chk("rises_max", 32'(rises), 32'd4112);
        chk("done_cycle_max", 32'(done_t), 32'd8225);
        chk("rd_pulses_max", 32'(rd_seen), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
